// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - op/state encodings and op-class helpers shared by muldiv_unit
package muldiv_pkg;

  // funct3 order: bit 2 picks the divide family, bits 1:0 pick the variant
  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } muldiv_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } muldiv_state_e;

  localparam int OP_CLASS_BIT = 2;  // 1: divide/remainder, 0: multiply
  localparam int OP_REM_BIT   = 1;  // within the divide family, 1: remainder

  function automatic logic op_is_div(input muldiv_op_e op);
    logic [2:0] v;
    v = op;
    return v[OP_CLASS_BIT];
  endfunction

  function automatic logic op_is_rem(input muldiv_op_e op);
    logic [2:0] v;
    v = op;
    return v[OP_CLASS_BIT] & v[OP_REM_BIT];
  endfunction

  function automatic logic op_is_signed_div(input muldiv_op_e op);
    return (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic op_a_signed(input muldiv_op_e op);
    return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic op_b_signed(input muldiv_op_e op);
    return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
  endfunction

endpackage

// File: rtl/muldiv_div_step.sv
// rtl/muldiv_div_step.sv - one combinational restoring-division iteration
module muldiv_div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] divisor,
  input  logic             dividend_bit,
  output logic [WIDTH-1:0] rem_next,
  output logic             q_bit
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  // Shift in the next dividend bit and trial-subtract. rem < divisor holds on
  // entry, so the (WIDTH+1)-bit difference's top bit is a clean borrow flag.
  always_comb begin
    shifted  = {rem, dividend_bit};
    diff     = shifted - {1'b0, divisor};
    q_bit    = ~diff[WIDTH];
    rem_next = q_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
  end

endmodule

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative RV32M multiply/divide unit; MULDIV_FAST_MUL_EN selects single-cycle multiply
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [2:0]       i_op,
  input  logic [WIDTH-1:0] i_operand_a,
  input  logic [WIDTH-1:0] i_operand_b,
  input  logic             i_flush,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_result
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  muldiv_state_e    state;
  muldiv_op_e       op_q;
  muldiv_op_e       op_in;
  logic [CW-1:0]    count;
  logic             neg_q;
  // acc_hi: product high half / partial remainder
  // acc_lo: multiplier being consumed / dividend shifting out, quotient shifting in
  // opnd:   multiplicand magnitude / divisor magnitude
  logic [WIDTH-1:0] acc_hi;
  logic [WIDTH-1:0] acc_lo;
  logic [WIDTH-1:0] opnd;

  logic             a_neg;
  logic             b_neg;
  logic             res_neg;
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;
  logic             early_hit;
  logic [WIDTH-1:0] early_res;

  logic [WIDTH:0]     mul_sum;
  logic [WIDTH-1:0]   div_rem;
  logic               div_qbit;
  logic [WIDTH-1:0]   hi_next;
  logic [WIDTH-1:0]   lo_next;
  logic [2*WIDTH-1:0] prod_signed;
  logic [WIDTH-1:0]   final_res;

  assign op_in   = muldiv_op_e'(i_op);
  assign o_ready = (state == IDLE);

  muldiv_div_step #(.WIDTH(WIDTH)) u_div_step (
    .rem          (acc_hi),
    .divisor      (opnd),
    .dividend_bit (acc_lo[WIDTH-1]),
    .rem_next     (div_rem),
    .q_bit        (div_qbit)
  );

  // Operand magnitudes, result sign and early-completion results at accept time
  always_comb begin
    a_neg     = op_a_signed(op_in) & i_operand_a[WIDTH-1];
    b_neg     = op_b_signed(op_in) & i_operand_b[WIDTH-1];
    mag_a     = a_neg ? -i_operand_a : i_operand_a;
    mag_b     = b_neg ? -i_operand_b : i_operand_b;
    // remainder follows the dividend; everything else is sign(a) xor sign(b)
    res_neg   = (op_in == OP_REM) ? a_neg : (a_neg ^ b_neg);
    early_hit = 1'b0;
    early_res = '0;
    if (op_is_div(op_in)) begin
      if (i_operand_b == '0) begin
        early_hit = 1'b1;
        early_res = op_is_rem(op_in) ? i_operand_a : '1;
      end else if (op_is_signed_div(op_in) && (i_operand_a == MOST_NEG) && (i_operand_b == '1)) begin
        early_hit = 1'b1;
        early_res = op_is_rem(op_in) ? '0 : i_operand_a;
      end
    end
`ifdef MULDIV_FAST_MUL_EN
    else begin
      logic [2*WIDTH-1:0] fast_prod;
      fast_prod = {{WIDTH{1'b0}}, mag_a} * {{WIDTH{1'b0}}, mag_b};
      if (res_neg) fast_prod = -fast_prod;
      early_hit = 1'b1;
      early_res = (op_in == OP_MUL) ? fast_prod[WIDTH-1:0] : fast_prod[2*WIDTH-1:WIDTH];
    end
`endif
  end

  // One shift-add or restoring step, plus the sign-corrected result of the last step
  always_comb begin
    mul_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
    if (op_is_div(op_q)) begin
      hi_next = div_rem;
      lo_next = {acc_lo[WIDTH-2:0], div_qbit};
    end else begin
      hi_next = mul_sum[WIDTH:1];
      lo_next = {mul_sum[0], acc_lo[WIDTH-1:1]};
    end
    prod_signed = neg_q ? -{hi_next, lo_next} : {hi_next, lo_next};
    case (op_q)
      OP_MUL:                      final_res = prod_signed[WIDTH-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: final_res = prod_signed[2*WIDTH-1:WIDTH];
      OP_DIV, OP_DIVU:             final_res = neg_q ? -lo_next : lo_next;
      default:                     final_res = neg_q ? -hi_next : hi_next;
    endcase
  end

  // Control FSM with datapath registers; flush overrides every transition
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state    <= IDLE;
      op_q     <= OP_MUL;
      count    <= '0;
      neg_q    <= 1'b0;
      acc_hi   <= '0;
      acc_lo   <= '0;
      opnd     <= '0;
      o_valid  <= 1'b0;
      o_result <= '0;
    end else if (i_flush) begin
      state   <= IDLE;
      count   <= '0;
      o_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (i_valid) begin
            op_q  <= op_in;
            neg_q <= res_neg;
            if (early_hit) begin
              o_result <= early_res;
              o_valid  <= 1'b1;
              state    <= DONE;
            end else begin
              acc_hi <= '0;
              acc_lo <= op_is_div(op_in) ? mag_a : mag_b;
              opnd   <= op_is_div(op_in) ? mag_b : mag_a;
              count  <= CW'(WIDTH - 1);
              state  <= CALC;
            end
          end
        end
        CALC: begin
          acc_hi <= hi_next;
          acc_lo <= lo_next;
          if (count == '0) begin
            o_result <= final_res;
            o_valid  <= 1'b1;
            state    <= DONE;
          end else begin
            count <= count - CW'(1);
          end
        end
        DONE: begin
          if (i_ready) begin
            o_valid <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - randomized self-checking bench for muldiv_unit against an arithmetic model
module tb_muldiv_unit;

  localparam int W = 32;

  logic         i_clk = 1'b0;
  logic         i_rst_n = 1'b0;
  logic         i_valid = 1'b0;
  logic         i_flush = 1'b0;
  logic         i_ready = 1'b0;
  logic [2:0]   i_op = 3'd0;
  logic [W-1:0] i_operand_a = '0;
  logic [W-1:0] i_operand_b = '0;
  logic         o_ready;
  logic         o_valid;
  logic [W-1:0] o_result;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  bit          pend = 0;
  bit          pend_seen = 0;
  logic [31:0] pend_res = '0;
  int          pend_lat = 0;
  int          pend_acc = 0;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          stall;
    bit          poke;
  } vec_t;

  vec_t vecs[12];

  muldiv_unit #(.WIDTH(W)) dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_valid     (i_valid),
    .o_ready     (o_ready),
    .i_op        (i_op),
    .i_operand_a (i_operand_a),
    .i_operand_b (i_operand_b),
    .i_flush     (i_flush),
    .o_valid     (o_valid),
    .i_ready     (i_ready),
    .o_result    (o_result)
  );

  always #5 i_clk = ~i_clk;

  always @(posedge i_clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d tests so far", tests);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // RV32M semantics from 64-bit arithmetic
  function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    longint      sa;
    longint      sb;
    logic [31:0] r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    p  = '0;
    r  = '0;
    case (op)
      3'd0: begin p = 64'(sa * sb); r = p[31:0]; end
      3'd1: begin p = 64'(sa * sb); r = p[63:32]; end
      3'd2: begin p = 64'(sa * longint'({32'b0, b})); r = p[63:32]; end
      3'd3: begin p = {32'b0, a} * {32'b0, b}; r = p[63:32]; end
      3'd4: r = (b == 0) ? 32'hFFFFFFFF : 32'(sa / sb);
      3'd5: r = (b == 0) ? 32'hFFFFFFFF : a / b;
      3'd6: r = (b == 0) ? a : 32'(sa % sb);
      default: r = (b == 0) ? a : a % b;
    endcase
    return r;
  endfunction

  function automatic int exp_lat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    if (op[2]) begin
      if (b == 0) return 1;
      if (!op[0] && a == 32'h80000000 && b == 32'hFFFFFFFF) return 1;
      return 33;
    end
`ifdef MULDIV_FAST_MUL_EN
    return 1;
`else
    return 33;
`endif
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'hFFFFFFFF;
      2: return 32'h80000000;
      3: return 32'($urandom_range(0, 20));
      4: return -32'($urandom_range(1, 20));
      default: return $urandom;
    endcase
  endfunction

  // Whenever a result is presented it must match the model, arrive with the
  // expected latency, and the unit must not be ready at the same time
  always @(negedge i_clk) begin
    if (i_rst_n && o_valid) begin
      if (!pend) begin
        check("spurious_valid", o_valid, 1'b0);
      end else begin
        if (!pend_seen) begin
          check("latency", 64'(cyc - pend_acc), 64'(pend_lat));
          pend_seen = 1;
        end
        check("result", o_result, pend_res);
        check("ready_in_done", o_ready, 1'b0);
      end
    end
  end

  task automatic start_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    int n;
    n = 0;
    while (!o_ready && n < 200) begin
      @(negedge i_clk);
      n++;
    end
    check("ready_wait", o_ready, 1'b1);
    pend_res  = model(op, a, b);
    pend_lat  = exp_lat(op, a, b);
    pend_acc  = cyc;
    pend_seen = 0;
    pend      = 1;
    i_valid = 1'b1;
    i_op = op;
    i_operand_a = a;
    i_operand_b = b;
    @(negedge i_clk);
    i_valid = 1'b0;
    i_op = 3'($urandom);
    i_operand_a = $urandom;
    i_operand_b = $urandom;
  endtask

  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int stall, input bit poke);
    int n;
    start_op(op, a, b);
    n = 0;
    while (!o_valid && n < 200) begin
      @(negedge i_clk);
      n++;
    end
    if (!o_valid) begin
      check("valid_timeout", o_valid, 1'b1);
      pend = 0;
      return;
    end
    for (int i = 0; i < stall; i++) begin
      check("valid_held", o_valid, 1'b1);
      i_valid = poke ? 1'b1 : 1'($urandom_range(0, 1));
      i_op = 3'($urandom);
      i_operand_a = $urandom;
      i_operand_b = $urandom;
      @(negedge i_clk);
    end
    i_valid = 1'b0;
    i_ready = 1'b1;
    @(negedge i_clk);
    i_ready = 1'b0;
    pend = 0;
    check("idle_after_ack", {o_ready, o_valid}, 2'b10);
  endtask

  initial begin
    vecs[0]  = '{3'd0, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 5, 1};
    vecs[1]  = '{3'd1, 32'h80000000, 32'h80000000, 32'h40000000, 0, 0};
    vecs[2]  = '{3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1, 0};
    vecs[3]  = '{3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0};
    vecs[4]  = '{3'd4, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 2, 0};
    vecs[5]  = '{3'd6, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 0, 0};
    vecs[6]  = '{3'd5, 32'd100,      32'd7,        32'h0000000E, 0, 0};
    vecs[7]  = '{3'd7, 32'd100,      32'd7,        32'h00000002, 3, 0};
    vecs[8]  = '{3'd4, 32'd5,        32'd0,        32'hFFFFFFFF, 0, 0};
    vecs[9]  = '{3'd6, 32'd5,        32'd0,        32'h00000005, 1, 0};
    vecs[10] = '{3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 0, 0};
    vecs[11] = '{3'd6, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 0, 0};

    repeat (3) @(negedge i_clk);
    check("reset_ready", o_ready, 1'b1);
    check("reset_valid", o_valid, 1'b0);
    check("reset_result", o_result, '0);
    i_rst_n = 1'b1;
    @(negedge i_clk);

    // directed vectors, each pinning the model to a hand-computed value
    foreach (vecs[i]) begin
      check("model_pin", model(vecs[i].op, vecs[i].a, vecs[i].b), vecs[i].exp);
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].stall, vecs[i].poke);
    end

    // flush in IDLE blocks an accept that would otherwise complete next cycle
    i_valid = 1'b1;
    i_op = 3'd4;
    i_operand_a = 32'd5;
    i_operand_b = 32'd0;
    i_flush = 1'b1;
    @(negedge i_clk);
    i_valid = 1'b0;
    i_flush = 1'b0;
    check("flush_idle_block", {o_ready, o_valid}, 2'b10);
    @(negedge i_clk);
    check("flush_idle_block2", {o_ready, o_valid}, 2'b10);

    // flush mid-calculation, then a fresh divide
    start_op(3'd5, $urandom, 32'd7);
    repeat (9) @(negedge i_clk);
    check("calc_busy", {o_ready, o_valid}, 2'b00);
    i_flush = 1'b1;
    pend = 0;
    @(negedge i_clk);
    i_flush = 1'b0;
    check("flush_calc_idle", {o_ready, o_valid}, 2'b10);
    repeat (40) @(negedge i_clk);
    check("model_pin_divu", model(3'd5, 32'd9, 32'd3), 32'd3);
    run_op(3'd5, 32'd9, 32'd3, 0, 0);

    // asynchronous reset mid-calculation
    start_op(3'd1, $urandom, $urandom);
    repeat (5) @(negedge i_clk);
    pend = 0;
    i_rst_n = 1'b0;
    #1;
    check("rst_ready", o_ready, 1'b1);
    check("rst_valid", o_valid, 1'b0);
    check("rst_result", o_result, '0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    repeat (40) @(negedge i_clk);
    check("post_rst_idle", {o_ready, o_valid}, 2'b10);

    // randomized traffic
    for (int k = 0; k < 150; k++) begin
      run_op(3'($urandom), pick(), pick(), $urandom_range(0, 3), 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
